// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arb_state_t : two-state arbiter FSM encoding (IDLE / ACCESS)
//   REQ0, REQ1  : requester identifiers used for sel / owner / last
//   LOCK_CW     : width of the consecutive-grant lock counter (MAX_LOCK <= 15)
package dmem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int LOCK_CW = 4;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way winner select for the data-memory arbiter.
// A live lock (locked with the owner still requesting) hands the win to the
// owner outright; otherwise a lone requester wins and a tie goes to ~last.
// Ports:
//   req0, req1 : access requests
//   last       : requester granted most recently
//   locked     : lock currently held
//   owner      : lock owner
//   winner     : selected requester (REQ0 / REQ1)
//   valid      : a winner exists this cycle
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic locked,
  input  logic owner,
  output logic winner,
  output logic valid
);

  logic owner_req;

  always_comb begin
    owner_req = (owner == REQ1) ? req1 : req0;
    winner    = REQ0;
    valid     = 1'b0;
    if (locked && owner_req) begin
      winner = owner;
      valid  = 1'b1;
    end else if (req0 && req1) begin
      winner = ~last;
      valid  = 1'b1;
    end else if (req0) begin
      winner = REQ0;
      valid  = 1'b1;
    end else if (req1) begin
      winner = REQ1;
      valid  = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing a single-port data memory between requester 0
// (CPU data port) and requester 1 (loader/DMA port). Each access takes an
// IDLE grant cycle followed by one ACCESS cycle; read data returns one cycle
// after ack. A requester asserting lock keeps the memory for up to
// MAX_LOCK consecutive grants.
// Ports:
//   clk, rst                         : clock, asynchronous active-low reset
//   reqN, weN, lockN, addrN, wdataN  : requester N request / write / lock / address / data
//   ackN                             : access performed this cycle for requester N
//   rvalidN, rdataN                  : read completion for requester N
//   mem_A, mem_WD, mem_WE            : data memory address / write data / write enable
//   mem_RD                           : data memory combinational read data
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic          lock0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic          lock1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_A,
  output logic [DW-1:0] mem_WD,
  output logic          mem_WE,
  input  logic [DW-1:0] mem_RD
);

  arb_state_t          state, state_nxt;
  logic                sel, last, locked, owner;
  logic [LOCK_CW-1:0]  lock_cnt;
  logic [LOCK_CW:0]    lock_cnt_inc;
  logic                pick_win, pick_vld;
  logic                grant, owner_req, lock_live, lock_req, lock_ok;
  logic                rd_done;

  logic [AW-1:0]       addr_p1;
  logic [DW-1:0]       wdata_p1;
  logic                we_p1;

  rr_pick2 u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last),
    .locked (locked),
    .owner  (owner),
    .winner (pick_win),
    .valid  (pick_vld)
  );

  assign grant        = (state == IDLE) && pick_vld;
  assign owner_req    = (owner == REQ1) ? req1 : req0;
  // A lock whose owner has stopped requesting is treated as already released.
  assign lock_live    = locked && owner_req;
  assign lock_req     = (pick_win == REQ1) ? lock1 : lock0;
  assign lock_cnt_inc = {1'b0, lock_cnt} + 1'b1;
  assign lock_ok      = lock_req && (!lock_live || (owner == pick_win)) &&
                        (lock_cnt_inc < (LOCK_CW+1)'(MAX_LOCK));
  assign rd_done      = (state == ACCESS) && !we_p1;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = ACCESS;
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: memory port and acks are driven only in ACCESS
  always_comb begin
    mem_A  = '0;
    mem_WD = '0;
    mem_WE = 1'b0;
    ack0   = 1'b0;
    ack1   = 1'b0;
    if (state == ACCESS) begin
      mem_A  = addr_p1;
      mem_WD = wdata_p1;
      mem_WE = we_p1;
      ack0   = (sel == REQ0);
      ack1   = (sel == REQ1);
    end
  end

  // Grant bookkeeping: selection, round-robin history and lock tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel      <= REQ0;
      last     <= REQ1;
      locked   <= 1'b0;
      owner    <= REQ0;
      lock_cnt <= '0;
    end else if (state == IDLE) begin
      if (locked && !owner_req) begin
        locked   <= 1'b0;
        lock_cnt <= '0;
      end
      if (grant) begin
        sel  <= pick_win;
        last <= pick_win;
        if (lock_ok) begin
          locked   <= 1'b1;
          owner    <= pick_win;
          lock_cnt <= lock_cnt_inc[LOCK_CW-1:0];
        end else begin
          locked   <= 1'b0;
          lock_cnt <= '0;
        end
      end
    end
  end

  // Stage p1: access captured at grant; held steady through ACCESS
  always_ff @(posedge clk) begin
    if (grant) begin
      addr_p1  <= (pick_win == REQ1) ? addr1  : addr0;
      wdata_p1 <= (pick_win == REQ1) ? wdata1 : wdata0;
      we_p1    <= (pick_win == REQ1) ? we1    : we0;
    end
  end

  // Stage p2: read return, one cycle after ack; rdata holds between reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= rd_done && (sel == REQ0);
      rvalid1 <= rd_done && (sel == REQ1);
      if (rd_done && (sel == REQ0)) rdata0 <= mem_RD;
      if (rd_done && (sel == REQ1)) rdata1 <= mem_RD;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single-port data_memory (combinational read on address, write on clock edge when write-enable is high) between requester 0 (CPU data port) and requester 1 (loader/DMA port).
- Uses a two-state FSM, round-robin tie-break and an optional bounded lock, so one requester can own the memory for consecutive accesses.
- Sits between the requesters and data_memory.
- Drives data_memory's address, write-data and write-enable ports, and receives its read-data output.

Parameters:
- DW, 32, data width.
- AW, 32, address width; byte address, passed through unchanged.
- MAX_LOCK, 4, maximum consecutive grants to a locked owner; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 access request; held high until ack0.
- we0  input  1  requester 0 write (1) / read (0).
- lock0  input  1  requester 0 requests lock ownership.
- addr0  input  AW  requester 0 address.
- wdata0  input  DW  requester 0 write data.
- ack0  output  1  requester 0 access performed this cycle.
- rvalid0  output  1  rdata0 valid (read completions only).
- rdata0  output  DW  requester 0 read data.
- req1, we1, lock1, addr1, wdata1, ack1, rvalid1, rdata1  same as the requester 0 set, for requester 1.
- mem_A  output  AW  data_memory address.
- mem_WD  output  DW  data_memory write data.
- mem_WE  output  1  data_memory write enable.
- mem_RD  input  DW  data_memory read data.

Behaviour:
- Reset (rst low, async):
  - state=IDLE, last=1 (requester 0 wins the first tie), locked=0, owner=0, lock_cnt=0.
  - All outputs are 0, including mem_WE; no write can occur while rst is low.
- States:
  - IDLE: memory outputs are all 0; no ack.
  - ACCESS: exactly one cycle.
- IDLE winner selection, in this priority order:
  - If locked and req[owner]=1: the owner wins; the other requester is ignored.
  - If locked and req[owner]=0: clear locked, then apply the normal rule in the same cycle.
  - Normal rule: a single requester wins; if both request, winner = ~last.
  - With no request, stay in IDLE.
- On a grant edge:
  - Latch sel, addr, wdata and we from the winner.
  - Set last=sel.
  - Go to ACCESS.
- Lock update on each grant:
  - If lock[sel]=1 and (not locked, or owner==sel) and lock_cnt+1 < MAX_LOCK: locked=1, owner=sel, lock_cnt=lock_cnt+1.
  - Otherwise: locked=0, lock_cnt=0.
  - MAX_LOCK=1 therefore never locks.
- ACCESS cycle:
  - Drive mem_A=latched addr, mem_WD=latched wdata, mem_WE=latched we.
  - ack[sel]=1 (combinational from state/sel), ack of the other requester=0.
  - At the closing edge:
    - If we=0: rdata[sel] <= mem_RD and rvalid[sel]=1 for the next cycle only.
    - If we=1: rdata is unchanged and no rvalid.
  - Next state is always IDLE.
- Timing:
  - Latency req -> ack is 2 cycles (IDLE grant edge, then ACCESS).
  - Read data appears one cycle after ack.
  - Peak throughput is 1 access per 2 cycles.
- Requester contract:
  - Hold req/we/addr/wdata/lock stable until ack is seen.
  - Deassert req, or present a new request, after the ack edge.
  - The arbiter latches at grant, so later changes do not affect the access in flight.
- rdata holds its last value between reads.
- rvalid on one port may coincide with ack on the other port.
- Reset during ACCESS: the state returns to IDLE asynchronously, mem_WE drops at once, and no ack or rvalid is produced.

Decomposition:
- Package dmem_arb_pkg:
  - typedef enum logic {IDLE, ACCESS} arb_state_t.
  - Constant REQ0=1'b0, REQ1=1'b1.
- One sub-module, rr_pick2: combinational winner select from (req0, req1, last, locked, owner). It returns the winner and a valid flag.

Test Plan:
- Reset then single reads:
  - rst low for 2 cycles, then high.
  - Preload mem[8]=55; req0 read addr 8.
  - Required: ack0 exactly 2 cycles after req0 rises, rdata0=55 with rvalid0 one cycle later, ack1/rvalid1 stay 0.
- Write then read back:
  - req1 write addr 4 data 10; then req1 read addr 4.
  - Required: mem_WE=1 only in the write ACCESS cycle, then rdata1=10.
- Simultaneous requests:
  - req0 and req1 both reads held high from reset.
  - Required: grants alternate 0,1,0,1; each requester gets one ack per 4 cycles.
- Lock with MAX_LOCK=4:
  - lock0=1, req0 held with addrs 0,4,8,12,16; req1 held continuously.
  - Required: requester 0 receives 4 consecutive acks, then requester 1 is acked before requester 0's fifth access.
- Lock release:
  - Owner 0 locked; req0 drops in IDLE while req1 is high.
  - Required: requester 1 is granted in that same IDLE cycle and locked clears.
- Reset mid-access:
  - Assert rst during an ACCESS write of 20 to addr 8.
  - Required: mem_WE falls immediately, no ack, FSM in IDLE, mem[8] not updated to 20.
